// File: rtl/exu_mdu.sv
// Iterative RV M-extension execute unit: shift-add multiplier and restoring divider
// retiring STEP bits per cycle, with one op in flight and a held output register.
module exu_mdu #(
    parameter int XLEN         = 32,
    parameter int STEP         = 1,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    localparam int N     = XLEN / STEP;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = '1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; the offering side holds its payload until then, ready never waits on valid.
    assign in_ready_o = (state == S_IDLE);
    assign busy_o     = (state != S_IDLE);

    logic            is_div, a_signed, b_signed, sa, sb, neg_in, special;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    always_comb begin
        is_div   = op_i[2];
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        sa       = a_signed & src1_i[XLEN-1];
        sb       = b_signed & src2_i[XLEN-1];
        mag_a    = sa ? -src1_i : src1_i;
        mag_b    = sb ? -src2_i : src2_i;
        // A zero divisor must give an all-ones quotient whatever the dividend sign.
        if (!is_div)
            neg_in = sa ^ sb;
        else if (op_i[1])
            neg_in = sa;
        else
            neg_in = (sa ^ sb) & (src2_i != '0);
        special  = 1'b0;
        spec_res = '0;
        if (is_div && src2_i == '0) begin
            special  = 1'b1;
            spec_res = op_i[1] ? src1_i : ALL_ONE;
        end else if (is_div && b_signed && src1_i == MIN_VAL && src2_i == ALL_ONE) begin
            special  = 1'b1;
            spec_res = op_i[1] ? '0 : src1_i;
        end
    end

    logic [XLEN-1:0]   m_hi, m_lo, d_rem, d_quo;
    logic [XLEN:0]     sum, trial;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        m_hi  = acc_hi;
        m_lo  = acc_lo;
        d_rem = acc_hi;
        d_quo = acc_lo;
        sum   = '0;
        trial = '0;
        for (int i = 0; i < STEP; i++) begin
            sum   = {1'b0, m_hi} + (m_lo[0] ? {1'b0, opa} : '0);
            m_lo  = {sum[0], m_lo[XLEN-1:1]};
            m_hi  = sum[XLEN:1];
            trial = {d_rem, d_quo[XLEN-1]} - {1'b0, opa};
            // Remainder stays below the divisor, so trial's top bit is a clean borrow.
            d_rem = trial[XLEN] ? {d_rem[XLEN-2:0], d_quo[XLEN-1]} : trial[XLEN-1:0];
            d_quo = {d_quo[XLEN-2:0], ~trial[XLEN]};
        end
        prod   = {m_hi, m_lo};
        prod_s = neg_q ? -prod : prod;
        case (op_q)
            3'd0:          fin_res = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fin_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fin_res = neg_q ? -d_quo : d_quo;
            default:       fin_res = neg_q ? -d_rem : d_rem;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            opa         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            res_o       <= '0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid_i && !flush_i) begin
                        op_q   <= op_i;
                        neg_q  <= neg_in;
                        cnt    <= CNT_W'(N);
                        acc_hi <= '0;
                        // Multiply: opa=multiplicand, lo=multiplier; divide: opa=divisor, lo=dividend.
                        opa    <= is_div ? mag_b : mag_a;
                        acc_lo <= is_div ? mag_a : mag_b;
                        if (FAST_SPECIAL && special) begin
                            res_o       <= spec_res;
                            out_valid_o <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= op_q[2] ? d_rem : m_hi;
                        acc_lo <= op_q[2] ? d_quo : m_lo;
                        cnt    <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            res_o       <= fin_res;
                            out_valid_o <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush_i || out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exu_mdu.sv
// Bench for exu_mdu: four instances (32/1 fast, 32/1 slow, 64/2 fast, 64/4 slow) checked
// against a wide-integer arithmetic model of the M-extension rules.
module tb_exu_mdu;

    logic        clock = 1'b0;
    logic        reset, flush, out_ready;
    logic [2:0]  op;
    logic [63:0] src1, src2;
    logic [3:0]  vld, rdy, ov, bz;
    logic [31:0] res_a, res_b;
    logic [63:0] res_c, res_d;
    logic [63:0] res [4];

    int n_chk = 0;
    int n_err = 0;

    int xlen_of [4] = '{32, 32, 64, 64};
    int step_of [4] = '{1, 1, 2, 4};
    int fast_of [4] = '{1, 0, 1, 0};

    always #5 clock = ~clock;

    assign res[0] = {32'd0, res_a};
    assign res[1] = {32'd0, res_b};
    assign res[2] = res_c;
    assign res[3] = res_d;

    exu_mdu #(.XLEN(32), .STEP(1), .FAST_SPECIAL(1'b1)) u_a (
        .clock(clock), .reset(reset), .flush_i(flush), .in_valid_i(vld[0]), .in_ready_o(rdy[0]),
        .op_i(op), .src1_i(src1[31:0]), .src2_i(src2[31:0]), .out_valid_o(ov[0]),
        .out_ready_i(out_ready), .res_o(res_a), .busy_o(bz[0]));
    exu_mdu #(.XLEN(32), .STEP(1), .FAST_SPECIAL(1'b0)) u_b (
        .clock(clock), .reset(reset), .flush_i(flush), .in_valid_i(vld[1]), .in_ready_o(rdy[1]),
        .op_i(op), .src1_i(src1[31:0]), .src2_i(src2[31:0]), .out_valid_o(ov[1]),
        .out_ready_i(out_ready), .res_o(res_b), .busy_o(bz[1]));
    exu_mdu #(.XLEN(64), .STEP(2), .FAST_SPECIAL(1'b1)) u_c (
        .clock(clock), .reset(reset), .flush_i(flush), .in_valid_i(vld[2]), .in_ready_o(rdy[2]),
        .op_i(op), .src1_i(src1), .src2_i(src2), .out_valid_o(ov[2]),
        .out_ready_i(out_ready), .res_o(res_c), .busy_o(bz[2]));
    exu_mdu #(.XLEN(64), .STEP(4), .FAST_SPECIAL(1'b0)) u_d (
        .clock(clock), .reset(reset), .flush_i(flush), .in_valid_i(vld[3]), .in_ready_o(rdy[3]),
        .op_i(op), .src1_i(src1), .src2_i(src2), .out_valid_o(ov[3]),
        .out_ready_i(out_ready), .res_o(res_d), .busy_o(bz[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact signed/unsigned integer arithmetic on a wide signed type.
    function automatic logic [63:0] ref_mdu(input int xlen, input logic [2:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] m, ua, ub, sa, sb, r;
        logic ovf;
        m  = (130'sd1 <<< xlen) - 130'sd1;
        ua = $signed({66'd0, a}) & m;
        ub = $signed({66'd0, b}) & m;
        sa = ua[xlen-1] ? ua - m - 130'sd1 : ua;
        sb = ub[xlen-1] ? ub - m - 130'sd1 : ub;
        ovf = (sa == -((m + 130'sd1) >>> 1)) && (sb == -130'sd1);
        r = 130'sd0;
        case (o)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> xlen;
            3'd2: r = (sa * ub) >>> xlen;
            3'd3: r = (ua * ub) >>> xlen;
            3'd4: if (ub == 130'sd0) r = m; else if (ovf) r = ua; else r = sa / sb;
            3'd5: if (ub == 130'sd0) r = m; else r = ua / ub;
            3'd6: if (ub == 130'sd0) r = ua; else if (ovf) r = 130'sd0; else r = sa % sb;
            default: if (ub == 130'sd0) r = ua; else r = ua % ub;
        endcase
        return r[63:0] & m[63:0];
    endfunction

    function automatic int exp_lat(input int idx, input logic [2:0] o,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] msk, am, bm, mn;
        logic spc;
        msk = (xlen_of[idx] == 64) ? '1 : 64'hFFFF_FFFF;
        mn  = (xlen_of[idx] == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
        am  = a & msk;
        bm  = b & msk;
        spc = o[2] && (bm == 64'd0 || (!o[0] && am == mn && bm == msk));
        if (fast_of[idx] != 0 && spc) return 1;
        return xlen_of[idx] / step_of[idx] + 1;
    endfunction

    function automatic logic [63:0] rnd_operand(input int xlen);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = (xlen == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            2:       v = '1;
            3:       v = 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic do_op(input int idx, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res, input string tag);
        int   lat, el;
        logic rdy_seen;
        el = exp_lat(idx, o, a, b);
        @(negedge clock);
        out_ready = 1'b1;
        op = o; src1 = a; src2 = b; vld[idx] = 1'b1;
        @(posedge clock); #1;
        vld[idx] = 1'b0;
        op = 3'($urandom); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        lat = 1;
        rdy_seen = 1'b0;
        while (!ov[idx] && lat < 200) begin
            if (rdy[idx]) rdy_seen = 1'b1;
            @(posedge clock); #1;
            lat++;
        end
        if (rdy[idx]) rdy_seen = 1'b1;
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " result"}, res[idx] & ((xlen_of[idx] == 64) ? '1 : 64'hFFFF_FFFF), exp_res);
        check({tag, " in_ready low"}, {63'd0, rdy_seen}, 64'd0);
        @(posedge clock); #1;
        check({tag, " drained"}, {63'd0, ov[idx]}, 64'd0);
    endtask

    task automatic do_pair(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        int   lat;
        logic got_c, got_d;
        logic [63:0] exp_r;
        exp_r = ref_mdu(64, o, a, b);
        @(negedge clock);
        out_ready = 1'b1;
        op = o; src1 = a; src2 = b; vld[2] = 1'b1; vld[3] = 1'b1;
        @(posedge clock); #1;
        vld[2] = 1'b0; vld[3] = 1'b0;
        src1 = {$urandom, $urandom};
        lat = 1; got_c = 1'b0; got_d = 1'b0;
        while (lat < 200) begin
            if (!got_c && ov[2]) begin
                got_c = 1'b1;
                check("step2 latency", 64'(lat), 64'(exp_lat(2, o, a, b)));
                check("step2 result", res_c, exp_r);
            end
            if (!got_d && ov[3]) begin
                got_d = 1'b1;
                check("step4 latency", 64'(lat), 64'(exp_lat(3, o, a, b)));
                check("step4 result", res_d, exp_r);
            end
            if (got_c && got_d) break;
            @(posedge clock); #1;
            lat++;
        end
        check("pair completion", {62'd0, got_c, got_d}, 64'd3);
        @(posedge clock); #1;
    endtask

    initial begin
        logic [63:0] a, b;
        logic [2:0]  o;
        logic        hold_ok;
        int          lat;

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; vld = 4'd0;
        op = 3'd0; src1 = 64'd0; src2 = 64'd0;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("reset in_ready", {63'd0, rdy[i]}, 64'd1);
            check("reset busy", {63'd0, bz[i]}, 64'd0);
            check("reset out_valid", {63'd0, ov[i]}, 64'd0);
            check("reset res", res[i], 64'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        do_op(0, 3'd0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, "MUL 7*-3");
        do_op(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "MULH min*min");
        do_op(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "MULHU max*max");
        do_op(0, 3'd2, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF, "MULHSU -1*2");
        do_op(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, "DIV -7/2");
        do_op(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, "REM -7/2");
        do_op(0, 3'd5, 64'd100, 64'd7, 64'd14, "DIVU 100/7");
        do_op(0, 3'd7, 64'd100, 64'd7, 64'd2, "REMU 100/7");
        for (int i = 0; i < 2; i++) begin
            do_op(i, 3'd4, 64'd5, 64'd0, 64'hFFFF_FFFF, "DIV 5/0");
            do_op(i, 3'd6, 64'd5, 64'd0, 64'd5, "REM 5/0");
            do_op(i, 3'd4, 64'hFFFF_FFFB, 64'd0, 64'hFFFF_FFFF, "DIV -5/0");
            do_op(i, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "DIV ovf");
            do_op(i, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, "REM ovf");
        end

        for (int n = 0; n < 200; n++) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_operand(32);
            b = rnd_operand(32);
            do_op(n % 2, o, a, b, ref_mdu(32, o, a, b), "rand32");
        end

        // Backpressure: result held while the consumer stalls.
        @(negedge clock);
        out_ready = 1'b0; op = 3'd5; src1 = 64'd100; src2 = 64'd7; vld[0] = 1'b1;
        @(posedge clock); #1;
        vld[0] = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        check("stall latency", 64'(lat), 64'd33);
        hold_ok = 1'b1;
        repeat (10) begin
            @(posedge clock); #1;
            if (res[0] != 64'd14 || !ov[0] || rdy[0]) hold_ok = 1'b0;
        end
        check("stall hold", {63'd0, hold_ok}, 64'd1);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("stall drain valid", {63'd0, ov[0]}, 64'd0);
        check("stall drain ready", {63'd0, rdy[0]}, 64'd1);

        // Flush mid-CALC, then a new op on the very next edge.
        @(negedge clock);
        op = 3'd0; src1 = 64'd123; src2 = 64'd456; vld[0] = 1'b1;
        @(posedge clock); #1;
        vld[0] = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush calc valid", {63'd0, ov[0]}, 64'd0);
        check("flush calc ready", {63'd0, rdy[0]}, 64'd1);
        do_op(0, 3'd0, 64'd9, 64'd9, 64'd81, "post-flush MUL");

        // Flush while a result is held.
        @(negedge clock);
        out_ready = 1'b0; op = 3'd4; src1 = 64'd5; src2 = 64'd0; vld[0] = 1'b1;
        @(posedge clock); #1;
        vld[0] = 1'b0;
        check("flush done pre", {63'd0, ov[0]}, 64'd1);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush done valid", {63'd0, ov[0]}, 64'd0);
        check("flush done ready", {63'd0, rdy[0]}, 64'd1);
        out_ready = 1'b1;

        for (int n = 0; n < 1000; n++) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_operand(64);
            b = rnd_operand(64);
            if ($urandom_range(0, 9) == 0) begin
                a = 64'h8000_0000_0000_0000;
                b = '1;
            end
            do_pair(o, a, b);
        end

        // Reset mid-CALC.
        @(negedge clock);
        op = 3'd4; src1 = 64'd1000; src2 = 64'd3; vld[1] = 1'b1;
        @(posedge clock); #1;
        vld[1] = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid reset valid", {63'd0, ov[1]}, 64'd0);
        check("mid reset ready", {63'd0, rdy[1]}, 64'd1);
        check("mid reset busy", {63'd0, bz[1]}, 64'd0);
        check("mid reset res", res[1], 64'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/exu_mdu.md
Name: exu_mdu

Overview:
- Multi-cycle multiply/divide execute unit for the RV M extension.
- Sits in the E-stage beside the single-cycle ALU/branch path and takes over when the decoder flags an M-class op.
- Uses the same valid/ready handshake as the pipe stages: upstream E-pipe on the input side, downstream M-pipe on the output side.
- Iterative shift-add multiplier and restoring divider, parametrised in data width and bits retired per cycle; one op in flight; result held in an output register until taken.

Parameters:
- XLEN, 32, operand/result width; must be even, at least 8.
- STEP, 1, bits retired per iteration; 1, 2 or 4; must divide XLEN.
- FAST_SPECIAL, 1, when 1, div-by-zero and signed overflow finish without iterating.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  squash: abort in-flight op and drop held result.
- in_valid_i  in  1  E-pipe offers an op.
- in_ready_o  out  1  unit can accept an op.
- op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1_i  in  XLEN  rs1 operand.
- src2_i  in  XLEN  rs2 operand.
- out_valid_o  out  1  result available to M-pipe.
- out_ready_i  in  1  M-pipe accepts result.
- res_o  out  XLEN  result; only meaningful when out_valid_o=1.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, counter=0, res_o=0, out_valid_o=0, busy_o=0, in_ready_o=1. Reset overrides flush and the handshake.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & ~flush_i: latch op and operands; convert signed operands to magnitudes and record result signs.
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both operands signed.
  - Load counter=XLEN/STEP, go to CALC.
  - Divider special case with FAST_SPECIAL=1: go straight to DONE with the fixed result.
    - Divide by zero: DIV/DIVU give all-ones; REM/REMU give src1.
    - Signed overflow (DIV/REM, src1=100..0, src2=all-ones): DIV gives src1; REM gives 0.
  - With FAST_SPECIAL=0, special cases iterate normally and must yield the same values.
- CALC:
  - in_ready_o=0.
  - Each cycle retires STEP bits and decrements counter.
    - Multiply: 2*XLEN accumulator.
    - Divide: restoring, XLEN remainder plus quotient.
  - When counter reaches 1, the next edge applies sign correction, selects the result, loads res_o and goes to DONE.
    - MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits.
    - Quotient negated if operand signs differ. Remainder takes the sign of the dividend.
- DONE:
  - out_valid_o=1; res_o stable.
  - On out_ready_i: out_valid_o falls next cycle, state returns to IDLE.
  - No new op is accepted in the same cycle as a drain, so the earliest next accept is one cycle after the drain edge.
- Latency, accept edge to out_valid_o high:
  - Normal ops: XLEN/STEP+1 cycles (33 at defaults).
  - Fast special: 1 cycle.
- flush_i in CALC or DONE: next state IDLE, out_valid_o=0. res_o keeps its value; it must not be sampled.
- flush_i in IDLE suppresses acceptance that cycle.
- out_ready_i while not in DONE: ignored.
- Inputs changing during CALC: no effect, since operands are latched.
- All arithmetic is modulo 2^XLEN except the internal 2*XLEN product; no overflow flags.

Test Plan:
- MUL 7 x -3 (XLEN=32, STEP=1), out_ready_i=1 → res_o=0xFFFFFFEB; out_valid_o high exactly 33 cycles after accept; in_ready_o low throughout.
- MULH 0x80000000 x 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE; MULHSU -1 x 2 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, one cycle after accept with FAST_SPECIAL=1. DIV 0x80000000 / -1 → 0x80000000, REM → 0. Repeat with FAST_SPECIAL=0: same values at 33 cycles.
- Backpressure and abort:
  - Hold out_ready_i=0 for 10 cycles after done → res_o stable, out_valid_o held, in_ready_o=0.
  - Assert flush_i mid-CALC → out_valid_o never rises; next op accepted the cycle after.
- Sweep STEP=2 and STEP=4 with XLEN=64 against a reference model on 1000 random ops → latency XLEN/STEP+1 and results match. Reset asserted mid-CALC → all outputs back to reset values on the next edge.
